// File: rtl/nv_ram_rwsp_param.sv
// Single-port-per-direction RAM with a one-write/one-read interface, a
// self-initialising INIT sequence and a registered, separately enabled output stage.
module nv_ram_rwsp_param #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 160,
  parameter int               AW       = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  output logic             init_done,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam int              IW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q,     state_d;
  logic [AW-1:0]      init_cnt_q,  init_cnt_d;
  logic               init_done_q, init_done_d;
  logic [AW-1:0]      ra_d_q,      ra_d_d;
  logic               rd_pend_q,   rd_pend_d;
  logic [WIDTH-1:0]   dout_q,      dout_d;
  logic               dout_vld_q,  dout_vld_d;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic               mem_we_s;
  logic [IW-1:0]      mem_wa_s;
  logic [WIDTH-1:0]   mem_wd_s;
  logic [WIDTH-1:0]   rd_data_s;
  logic               wa_in_range_s;
  logic               ra_in_range_s;
  logic               unused_s;

  // Power-control bus has no functional effect.
  assign unused_s = ^pwrbus_ram_pd;

  assign wa_in_range_s = ({1'b0, wa}     < DEPTH_W);
  assign ra_in_range_s = ({1'b0, ra_d_q} < DEPTH_W);

  // Read port: combinational lookup of the captured address.
  always_comb begin
    rd_data_s = INIT_VAL;
    if (ra_in_range_s) begin
      rd_data_s = mem[ra_d_q[IW-1:0]];
    end else begin
      rd_data_s = INIT_VAL;
    end
  end

  // Write-port mux: the init sequence owns the port until RUN.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = {IW{1'b0}};
    mem_wd_s = INIT_VAL;
    if (state_q == ST_INIT) begin
      mem_we_s = 1'b1;
      mem_wa_s = init_cnt_q[IW-1:0];
      mem_wd_s = INIT_VAL;
    end else begin
      mem_we_s = we & wa_in_range_s;
      mem_wa_s = wa[IW-1:0];
      mem_wd_s = di;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_wa_s] <= mem_wd_s;
    end
  end

  // Next-state logic for the FSM, read-address capture and output stage.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    ra_d_d      = ra_d_q;
    rd_pend_d   = rd_pend_q;
    dout_d      = dout_q;
    dout_vld_d  = dout_vld_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          init_cnt_d  = {AW{1'b0}};
        end else begin
          init_cnt_d  = init_cnt_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        // ore samples the old ra_d/rd_pend; a same-edge re re-arms rd_pend.
        if (ore) begin
          dout_d     = rd_data_s;
          dout_vld_d = rd_pend_q;
          rd_pend_d  = 1'b0;
        end else begin
          dout_d     = dout_q;
          dout_vld_d = dout_vld_q;
        end
        if (re) begin
          ra_d_d    = ra;
          rd_pend_d = 1'b1;
        end else begin
          ra_d_d    = ra_d_q;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = {AW{1'b0}};
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= {AW{1'b0}};
      init_done_q <= 1'b0;
      ra_d_q      <= {AW{1'b0}};
      rd_pend_q   <= 1'b0;
      dout_q      <= {WIDTH{1'b0}};
      dout_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      ra_d_q      <= ra_d_d;
      rd_pend_q   <= rd_pend_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Directed-vector bench: default instance for the functional cases, plus a
// 32x1024 instance with a non-zero INIT_VAL for the mid-init reset case.
module tb_nv_ram_rwsp_param;

  logic        clk;
  logic        rst,  rst2;
  logic [7:0]  ra,   wa;
  logic        re,   ore,  we;
  logic [15:0] di;
  logic [15:0] dout;
  logic        dout_vld, init_done;
  logic [9:0]  ra2,  wa2;
  logic        re2,  ore2, we2;
  logic [31:0] di2;
  logic [31:0] dout2;
  logic        dout_vld2, init_done2;
  logic [31:0] pwr;

  int n_vec;
  int n_err;

  nv_ram_rwsp_param dut (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout),
    .dout_vld(dout_vld), .wa(wa), .we(we), .di(di), .init_done(init_done),
    .pwrbus_ram_pd(pwr)
  );

  nv_ram_rwsp_param #(
    .WIDTH(32), .DEPTH(1024), .AW(10), .INIT_VAL(32'hDEADBEEF)
  ) dut2 (
    .clk(clk), .rst(rst2), .ra(ra2), .re(re2), .ore(ore2), .dout(dout2),
    .dout_vld(dout_vld2), .wa(wa2), .we(we2), .di(di2), .init_done(init_done2),
    .pwrbus_ram_pd(pwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    we = 1'b1; wa = a; di = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [15:0] exp);
    re = 1'b1; ra = a;
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
    check_vec({tag, "_dout"}, {16'h0, dout}, {16'h0, exp});
    check_vec({tag, "_vld"}, {31'h0, dout_vld}, 32'h1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    pwr = 32'hFFFF_0000;
    rst = 1'b1; rst2 = 1'b1;
    ra = 8'd3; wa = 8'd3; re = 1'b1; ore = 1'b1; we = 1'b1; di = 16'hFFFF;
    ra2 = 10'd0; wa2 = 10'd10; re2 = 1'b0; ore2 = 1'b0; we2 = 1'b1; di2 = 32'h0;
    tick(); tick();
    check_vec("rst_init_done", {31'h0, init_done}, 32'h0);
    check_vec("rst_dout", {16'h0, dout}, 32'h0);
    check_vec("rst_vld", {31'h0, dout_vld}, 32'h0);

    // Reset again at init_cnt=80, then count the full sequence after release.
    rst = 1'b0;
    repeat (80) tick();
    rst = 1'b1;
    #1;
    check_vec("midinit_rst_done", {31'h0, init_done}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (159) tick();
    check_vec("init_done_159", {31'h0, init_done}, 32'h0);
    tick();
    check_vec("init_done_160", {31'h0, init_done}, 32'h1);
    check_vec("init_no_ore_dout", {16'h0, dout}, 32'h0);
    we = 1'b0; re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
    check_vec("init_no_re_capture", {31'h0, dout_vld}, 32'h0);
    do_read("init_no_user_write", 8'd3, 16'h0000);
    do_read("init_val_159", 8'd159, 16'h0000);

    do_write(8'd5, 16'hA5A5);
    do_read("wr_rd_5", 8'd5, 16'hA5A5);

    // Collision: ra_d=7 captured, write lands at N, ore at N+1 sees it.
    re = 1'b1; ra = 8'd7; tick(); re = 1'b0;
    do_write(8'd7, 16'h1234);
    ore = 1'b1; tick(); ore = 1'b0;
    check_vec("collision_dout", {16'h0, dout}, 32'h1234);
    check_vec("collision_vld", {31'h0, dout_vld}, 32'h1);

    // Same-edge write and ore: ore sees the old word, write still lands.
    re = 1'b1; ra = 8'd7; tick(); re = 1'b0;
    we = 1'b1; wa = 8'd7; di = 16'h5555; ore = 1'b1;
    tick();
    we = 1'b0;
    check_vec("same_edge_old", {16'h0, dout}, 32'h1234);
    tick();
    ore = 1'b0;
    check_vec("same_edge_new", {16'h0, dout}, 32'h5555);
    check_vec("same_edge_vld_clr", {31'h0, dout_vld}, 32'h0);

    do_write(8'd200, 16'hBEEF);
    do_read("oor_200", 8'd200, 16'h0000);
    do_read("oor_no_alias_40", 8'd40, 16'h0000);
    do_read("max_addr_255", 8'd255, 16'h0000);

    // Back-to-back pipelined reads.
    do_write(8'd0, 16'h1111);
    do_write(8'd1, 16'h2222);
    do_write(8'd2, 16'h3333);
    re = 1'b1; ra = 8'd0; tick();
    ra = 8'd1; ore = 1'b1; tick();
    check_vec("b2b_m0", {16'h0, dout}, 32'h1111);
    check_vec("b2b_v0", {31'h0, dout_vld}, 32'h1);
    ra = 8'd2; tick();
    check_vec("b2b_m1", {16'h0, dout}, 32'h2222);
    check_vec("b2b_v1", {31'h0, dout_vld}, 32'h1);
    re = 1'b0; tick();
    check_vec("b2b_m2", {16'h0, dout}, 32'h3333);
    check_vec("b2b_v2", {31'h0, dout_vld}, 32'h1);
    tick();
    check_vec("ore_no_pend_vld", {31'h0, dout_vld}, 32'h0);
    ore = 1'b0; re = 1'b1; ra = 8'd5; tick(); re = 1'b0;
    check_vec("hold_dout", {16'h0, dout}, 32'h3333);
    check_vec("hold_vld", {31'h0, dout_vld}, 32'h0);

    // Reset in RUN with a read pending.
    rst = 1'b1;
    #1;
    check_vec("run_rst_done", {31'h0, init_done}, 32'h0);
    check_vec("run_rst_dout", {16'h0, dout}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (160) tick();
    check_vec("rerun_done", {31'h0, init_done}, 32'h1);
    ore = 1'b1; tick(); ore = 1'b0;
    check_vec("rerun_pend_cancel", {31'h0, dout_vld}, 32'h0);
    do_read("rerun_reinit_5", 8'd5, 16'h0000);

    // Wide instance: mid-init reset, then every word must hold INIT_VAL.
    rst2 = 1'b0;
    repeat (80) tick();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    repeat (1023) tick();
    check_vec("w_done_1023", {31'h0, init_done2}, 32'h0);
    tick();
    check_vec("w_done_1024", {31'h0, init_done2}, 32'h1);
    we2 = 1'b0;
    re2 = 1'b1; ra2 = 10'd0; tick();
    ore2 = 1'b1;
    for (int i = 1; i <= 1024; i++) begin
      ra2 = 10'(i);
      re2 = (i < 1024);
      tick();
      check_vec($sformatf("w_word_%0d", i - 1), dout2, 32'hDEADBEEF);
    end
    check_vec("w_last_vld", {31'h0, dout_vld2}, 32'h1);
    ore2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
